// File: rtl/channelizer_pkg.sv
// Shared constants and types for the channelizer control path: message
// opcodes, default message width and the mask-parser state enumeration.
package channelizer_pkg;

  localparam int MSG_WIDTH_DEFAULT = 32;

  localparam logic [3:0] OP_SET_MASK  = 4'h1;
  localparam logic [3:0] OP_CLEAR_ERR = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_PAYLOAD,
    ST_PENDING
  } parser_state_e;

endpackage

// File: rtl/channel_mask_ctrl_if.sv
// Sample, message and status bundle of channel_mask_ctrl; the master side
// feeds samples/messages, the slave side is the mask controller.
interface channel_mask_ctrl_if
  import channelizer_pkg::*;
#(
  parameter int N         = 8,
  parameter int LOGN      = 3,
  parameter int WDTH      = 32,
  parameter int MWDTH     = 1,
  parameter int MSG_WIDTH = MSG_WIDTH_DEFAULT
);
  logic [WDTH-1:0]      in_data;
  logic                 in_nd;
  logic [MWDTH-1:0]     in_m;
  logic                 in_first;
  logic [MSG_WIDTH-1:0] in_msg;
  logic                 in_msg_nd;

  logic [WDTH-1:0]      out_data;
  logic                 out_nd;
  logic [MWDTH-1:0]     out_m;
  logic [LOGN-1:0]      out_channel;
  logic                 first_channel;
  logic [N-1:0]         active_mask;
  logic                 mask_applied;
  logic                 msg_error;
  logic                 unaligned;
  logic                 error;

  modport master (
    output in_data, in_nd, in_m, in_first, in_msg, in_msg_nd,
    input  out_data, out_nd, out_m, out_channel, first_channel,
           active_mask, mask_applied, msg_error, unaligned, error
  );

  modport slave (
    input  in_data, in_nd, in_m, in_first, in_msg, in_msg_nd,
    output out_data, out_nd, out_m, out_channel, first_channel,
           active_mask, mask_applied, msg_error, unaligned, error
  );
endinterface

// File: rtl/chmask_msg_parser.sv
// Control-message parser: decodes SET_MASK/CLEAR_ERR, holds the shadow mask
// and signals when a pending mask may be committed at a frame boundary.
module chmask_msg_parser
  import channelizer_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSG_WIDTH = MSG_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MSG_WIDTH-1:0] msg_i,
  input  logic                 msg_nd_i,
  input  logic                 boundary_i,
  output logic [N-1:0]         shadow_o,
  output logic                 apply_o,
  output logic                 clear_err_o,
  output logic                 bad_op_o
);
  parser_state_e  state_q, state_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [3:0]     op;

  assign op       = msg_i[MSG_WIDTH-1 -: 4];
  assign shadow_o = shadow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    apply_o     = 1'b0;
    clear_err_o = 1'b0;
    bad_op_o    = 1'b0;
    case (state_q)
      ST_IDLE, ST_PENDING: begin
        if (state_q == ST_PENDING && boundary_i) begin
          apply_o = 1'b1;
          state_d = ST_IDLE;
        end
        // A header here restarts the message; any uncommitted shadow is dropped.
        if (msg_nd_i) begin
          if (op == OP_SET_MASK)       state_d     = ST_WAIT_PAYLOAD;
          else if (op == OP_CLEAR_ERR) clear_err_o = 1'b1;
          else                         bad_op_o    = 1'b1;
        end
      end
      ST_WAIT_PAYLOAD: begin
        if (msg_nd_i) begin
          shadow_d = msg_i[N-1:0];
          state_d  = ST_PENDING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/channel_mask_ctrl.sv
// Channel mask controller: tracks the bin index of a channelized stream,
// gates bins by the active mask and swaps masks only on frame boundaries.
module channel_mask_ctrl
  import channelizer_pkg::*;
#(
  parameter int N         = 8,
  parameter int LOGN      = 3,
  parameter int WDTH      = 32,
  parameter int MWDTH     = 1,
  parameter int MSG_WIDTH = MSG_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  channel_mask_ctrl_if.slave  bus
);
  logic [LOGN-1:0]  cnt_q, cnt_d, ch;
  logic [N-1:0]     mask_q, mask_d, shadow;
  logic             resync, misalign, boundary, apply, clear_err, bad_op, kept;
  logic             first_pend_q, first_pend_d;
  logic             out_nd_q, first_q, applied_q, msg_err_q, unal_q, unal_set;
  logic [WDTH-1:0]  out_data_q;
  logic [MWDTH-1:0] out_m_q;
  logic [LOGN-1:0]  out_ch_q;

  chmask_msg_parser #(.N(N), .MSG_WIDTH(MSG_WIDTH)) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .msg_i       (bus.in_msg),
    .msg_nd_i    (bus.in_msg_nd),
    .boundary_i  (boundary),
    .shadow_o    (shadow),
    .apply_o     (apply),
    .clear_err_o (clear_err),
    .bad_op_o    (bad_op)
  );

  // A misplaced first-bin flag resyncs the sample to channel 0.
  assign resync   = bus.in_nd && bus.in_first && (cnt_q != '0);
  assign misalign = bus.in_nd && !bus.in_first && (cnt_q == '0);
  assign unal_set = resync || misalign;
  assign ch       = resync ? '0 : cnt_q;
  assign boundary = bus.in_nd && (ch == '0);
  assign cnt_d    = bus.in_nd ? ch + 1'b1 : cnt_q;

  // The boundary sample itself already sees a newly committed mask.
  assign mask_d = apply ? shadow : mask_q;
  assign kept   = bus.in_nd && mask_d[ch];
  assign first_pend_d = bus.in_nd ? (!kept && (ch == '0 || first_pend_q)) : first_pend_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      mask_q       <= '1;
      first_pend_q <= 1'b0;
      out_nd_q     <= 1'b0;
      first_q      <= 1'b0;
      applied_q    <= 1'b0;
      msg_err_q    <= 1'b0;
      unal_q       <= 1'b0;
      out_data_q   <= '0;
      out_m_q      <= '0;
      out_ch_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      first_pend_q <= first_pend_d;
      out_nd_q     <= kept;
      first_q      <= kept && (ch == '0 || first_pend_q);
      applied_q    <= apply;
      msg_err_q    <= bad_op   ? 1'b1 : (clear_err ? 1'b0 : msg_err_q);
      unal_q       <= unal_set ? 1'b1 : (clear_err ? 1'b0 : unal_q);
      if (kept) begin
        out_data_q <= bus.in_data;
        out_m_q    <= bus.in_m;
        out_ch_q   <= ch;
      end
    end
  end

  assign bus.out_data      = out_data_q;
  assign bus.out_nd        = out_nd_q;
  assign bus.out_m         = out_m_q;
  assign bus.out_channel   = out_ch_q;
  assign bus.first_channel = first_q;
  assign bus.active_mask   = mask_q;
  assign bus.mask_applied  = applied_q;
  assign bus.msg_error     = msg_err_q;
  assign bus.unaligned     = unal_q;
  assign bus.error         = msg_err_q || unal_q;
endmodule

// File: tb/tb_channel_mask_ctrl.sv
// Bench for channel_mask_ctrl: table vectors, directed mask/alignment
// sequences and randomized traffic checked against a frame-level model.
module tb_channel_mask_ctrl;
  import channelizer_pkg::*;

  localparam int N = 8, LOGN = 3, WDTH = 32, MWDTH = 1, MW = 32;
  localparam logic [31:0] HDR = 32'h1000_0000;
  localparam logic [31:0] CLR = 32'h2000_0000;
  localparam logic [31:0] BAD = 32'h7000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  channel_mask_ctrl_if #(.N(N), .LOGN(LOGN), .WDTH(WDTH), .MWDTH(MWDTH), .MSG_WIDTH(MW)) bus();

  channel_mask_ctrl #(.N(N), .LOGN(LOGN), .WDTH(WDTH), .MWDTH(MWDTH), .MSG_WIDTH(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int          m_cnt, m_out_ch;
  logic [7:0]  m_mask, m_shadow;
  bit          m_wait, m_pend, m_msgerr, m_unal, m_done;
  bit          m_out_nd, m_first, m_applied;
  logic [31:0] m_out_data;
  logic        m_out_m;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit nd, input bit first, input logic [31:0] d,
                            input logic mm, input bit mnd, input logic [31:0] msg);
    int ch;
    bit unal_set, bnd, apply, kept, clr, bad;
    logic [7:0] nm;
    int op;
    if (!rst) begin
      m_cnt = 0; m_mask = 8'hFF; m_shadow = 8'hFF; m_wait = 0; m_pend = 0;
      m_msgerr = 0; m_unal = 0; m_done = 0; m_out_nd = 0; m_first = 0;
      m_applied = 0; m_out_data = 0; m_out_m = 0; m_out_ch = 0;
      return;
    end
    ch = m_cnt;
    unal_set = 0;
    if (nd) begin
      if (first && ch != 0) begin unal_set = 1; ch = 0; end
      else if (!first && ch == 0) unal_set = 1;
    end
    bnd   = nd && (ch == 0);
    apply = m_pend && bnd;
    nm    = apply ? m_shadow : m_mask;
    kept  = nd && nm[ch];
    m_applied = apply;
    m_out_nd  = kept;
    if (nd) begin
      if (ch == 0) begin m_first = kept; m_done = kept; end
      else begin m_first = kept && !m_done; m_done = m_done || kept; end
      m_cnt = (ch + 1) % N;
    end else begin
      m_first = 0;
    end
    if (kept) begin m_out_data = d; m_out_m = mm; m_out_ch = ch; end
    m_mask = nm;
    if (apply) m_pend = 0;
    clr = 0; bad = 0;
    op = int'(msg[31:28]);
    if (mnd) begin
      if (m_wait) begin m_shadow = msg[7:0]; m_wait = 0; m_pend = 1; end
      else if (op == 1) begin m_wait = 1; m_pend = 0; end
      else if (op == 2) clr = 1;
      else bad = 1;
    end
    m_msgerr = bad ? 1'b1 : (clr ? 1'b0 : m_msgerr);
    m_unal   = unal_set ? 1'b1 : (clr ? 1'b0 : m_unal);
  endtask

  task automatic cyc(input bit rst, input bit nd, input bit first, input logic [31:0] d,
                     input bit mnd, input logic [31:0] msg);
    logic mm;
    mm = 1'($urandom);
    rst_n = rst; bus.in_nd = nd; bus.in_first = first; bus.in_data = d;
    bus.in_m = mm; bus.in_msg_nd = mnd; bus.in_msg = msg;
    model_step(rst, nd, first, d, mm, mnd, msg);
    @(posedge clk);
    #1;
    chk("out_nd", bus.out_nd, m_out_nd);
    chk("out_data", bus.out_data, m_out_data);
    chk("out_m", bus.out_m, m_out_m);
    chk("out_channel", bus.out_channel, m_out_ch);
    chk("first_channel", bus.first_channel, m_first);
    chk("active_mask", bus.active_mask, m_mask);
    chk("mask_applied", bus.mask_applied, m_applied);
    chk("msg_error", bus.msg_error, m_msgerr);
    chk("unaligned", bus.unaligned, m_unal);
    chk("error", bus.error, m_msgerr || m_unal);
  endtask

  task automatic smp(input bit first, input logic [31:0] d, input bit mnd = 1'b0,
                     input logic [31:0] msg = 32'h0);
    cyc(1'b1, 1'b1, first, d, mnd, msg);
  endtask

  typedef struct {
    bit          nd;
    bit          first;
    logic [31:0] data;
    bit          exp_nd;
    int          exp_ch;
    bit          exp_first;
  } vec_t;

  vec_t tbl[18];
  int   pulses;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].nd = 1; tbl[i].first = (i % 8 == 0); tbl[i].data = 32'(i * 3 + 1);
      tbl[i].exp_nd = 1; tbl[i].exp_ch = i % 8; tbl[i].exp_first = (i % 8 == 0);
    end
    for (int i = 16; i < 18; i++) begin
      tbl[i].nd = 0; tbl[i].first = 0; tbl[i].data = 32'hDEAD_BEEF;
      tbl[i].exp_nd = 0; tbl[i].exp_ch = 7; tbl[i].exp_first = 0;
    end

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_out_nd", bus.out_nd, 0);
    chk("rst_mask", bus.active_mask, 8'hFF);
    chk("rst_error", bus.error, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ch", bus.out_channel, 0);

    // Two aligned frames with the all-ones mask
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, tbl[i].nd, tbl[i].first, tbl[i].data, 1'b0, 32'h0);
      chk("tbl_out_nd", bus.out_nd, tbl[i].exp_nd);
      chk("tbl_out_ch", bus.out_channel, tbl[i].exp_ch);
      chk("tbl_first", bus.first_channel, tbl[i].exp_first);
      chk("tbl_error", bus.error, 0);
    end
    chk("tbl_hold_data", bus.out_data, 32'd46);

    // Mid-frame SET_MASK 0x05 waits for the next channel-0 sample
    smp(1, 100); smp(0, 101); smp(0, 102, 1, HDR); smp(0, 103, 1, 32'h05);
    for (int c = 4; c < 8; c++) begin
      smp(0, 32'(100 + c));
      chk("m05_premask", bus.active_mask, 8'hFF);
      chk("m05_pre_nd", bus.out_nd, 1);
      chk("m05_pre_applied", bus.mask_applied, 0);
    end
    smp(1, 200);
    chk("m05_applied", bus.mask_applied, 1);
    chk("m05_mask", bus.active_mask, 8'h05);
    chk("m05_ch0_nd", bus.out_nd, 1);
    for (int c = 1; c < 8; c++) begin
      smp(0, 32'(200 + c));
      chk("m05_nd", bus.out_nd, c == 2);
      chk("m05_applied_once", bus.mask_applied, 0);
    end

    // Two mask sequences in one frame: only the last commits
    pulses = 0;
    smp(1, 300, 1, HDR);   pulses += bus.mask_applied;
    smp(0, 301, 1, 32'h0F); pulses += bus.mask_applied;
    smp(0, 302, 1, HDR);   pulses += bus.mask_applied;
    smp(0, 303, 1, 32'hF0); pulses += bus.mask_applied;
    for (int c = 4; c < 8; c++) begin
      smp(0, 32'(300 + c)); pulses += bus.mask_applied;
      chk("mF0_old_mask_nd", bus.out_nd, 0);
    end
    smp(1, 400); pulses += bus.mask_applied;
    chk("mF0_mask", bus.active_mask, 8'hF0);
    chk("mF0_ch0_nd", bus.out_nd, 0);
    for (int c = 1; c < 8; c++) begin
      smp(0, 32'(400 + c)); pulses += bus.mask_applied;
      chk("mF0_nd", bus.out_nd, c >= 4);
    end
    chk("mF0_pulses", pulses, 1);

    // All-zero mask silences output until a new mask lands
    smp(1, 500, 1, HDR); smp(0, 501, 1, 32'h00);
    for (int c = 2; c < 8; c++) smp(0, 32'(500 + c));
    for (int c = 0; c < 8; c++) begin
      smp(c == 0, 32'(600 + c), c == 1 || c == 2, (c == 1) ? HDR : 32'hFF);
      chk("zero_nd", bus.out_nd, 0);
      chk("zero_mask", bus.active_mask, 8'h00);
    end
    smp(1, 700);
    chk("ff_restore_mask", bus.active_mask, 8'hFF);
    chk("ff_restore_nd", bus.out_nd, 1);

    // Misplaced first-bin flag resyncs; CLEAR_ERR clears it
    smp(0, 701); smp(0, 702);
    smp(1, 703);
    chk("resync_unal", bus.unaligned, 1);
    chk("resync_ch", bus.out_channel, 0);
    chk("resync_first", bus.first_channel, 1);
    chk("resync_error", bus.error, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, CLR);
    chk("clr_unal", bus.unaligned, 0);
    chk("clr_error", bus.error, 0);
    for (int c = 1; c < 8; c++) smp(0, 32'(800 + c));

    // Bad opcode, then reset in the middle of a message
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, BAD);
    chk("bad_msgerr", bus.msg_error, 1);
    chk("bad_error", bus.error, 1);
    chk("bad_mask", bus.active_mask, 8'hFF);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, CLR);
    chk("bad_clr", bus.msg_error, 0);
    smp(1, 900, 1, HDR);
    smp(0, 901, 1, 32'h0000_00F0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, HDR);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("mid_rst_mask", bus.active_mask, 8'hFF);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000);
    chk("mid_rst_hdr_decode", bus.msg_error, 1);
    smp(1, 950);
    chk("mid_rst_no_apply", bus.mask_applied, 0);
    chk("mid_rst_mask2", bus.active_mask, 8'hFF);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      bit rst, nd, first, mnd;
      logic [31:0] msg;
      int r;
      rst   = ($urandom_range(0, 199) != 0);
      nd    = ($urandom_range(0, 9) < 7);
      first = ($urandom_range(0, 19) == 0) ? 1'($urandom) : (m_cnt == 0);
      mnd   = ($urandom_range(0, 6) == 0);
      r     = $urandom_range(0, 9);
      if (r < 4)       msg = HDR;
      else if (r == 4) msg = CLR;
      else if (r == 5) msg = BAD | 32'($urandom_range(0, 255));
      else             msg = $urandom;
      cyc(rst, nd, first, $urandom, mnd, msg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
